// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer pot scan scheduler.
package eq_pkg;

  typedef enum logic [1:0] {GAP, ARB, WAIT, STORE} sched_state_t;

  localparam int unsigned NUM_SLOTS = 6;

  localparam int unsigned SLOT_LP  = 0;
  localparam int unsigned SLOT_B1  = 1;
  localparam int unsigned SLOT_B2  = 2;
  localparam int unsigned SLOT_B3  = 3;
  localparam int unsigned SLOT_HP  = 4;
  localparam int unsigned SLOT_VOL = 5;

  // Board wiring: which ADC128S input each slide pot lands on.
  localparam logic [2:0] SLOT_CHNL [NUM_SLOTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  function automatic logic [2:0] next_slot(input logic [2:0] slot);
    return (slot == 3'(NUM_SLOTS - 1)) ? 3'd0 : slot + 3'd1;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Shared interval counter: measures the inter-conversion gap and the conversion timeout.
module sched_timer #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == limit);

endmodule

// File: rtl/pot_scan_sched.sv
// Pot scan scheduler: round-robins the six slide pots through the shared A2D, interleaves
// host conversions, and holds the latest 12-bit reading per band.
module pot_scan_sched
  import eq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1024,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 strt_cnv,
  output logic [2:0]           chnnl,
  input  logic                 cnv_cmplt,
  input  logic [11:0]          res,
  input  logic                 hreq,
  input  logic [2:0]           hchnl,
  output logic                 hgnt,
  output logic [11:0]          hres,
  output logic                 hvld,
  output logic                 herr,
  output logic [11:0]          LP_gain,
  output logic [11:0]          B1_gain,
  output logic [11:0]          B2_gain,
  output logic [11:0]          B3_gain,
  output logic [11:0]          HP_gain,
  output logic [11:0]          VOLUME,
  output logic [NUM_SLOTS-1:0] gain_vld,
  output logic                 scan_err
);

  localparam int unsigned CntMax = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] GapLim  = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0] WaitLim = CntW'(TIMEOUT - 1);

  sched_state_t state_q, state_d;
  logic [2:0]   slot_q, slot_d;
  logic         last_host_q, last_host_d;
  logic         owner_host_q, owner_host_d;
  logic [2:0]   chnnl_q, chnnl_d;
  logic [11:0]  gain_q [NUM_SLOTS];
  logic [11:0]  gain_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] gain_vld_q, gain_vld_d;
  logic         scan_err_q, scan_err_d;
  logic [11:0]  hres_q, hres_d;
  logic         hvld_q, hvld_d;
  logic         herr_q, herr_d;

  logic            host_win;
  logic [2:0]      arb_chnl;
  logic            tmo_fire;
  logic            tmr_load, tmr_en, tmr_expired;
  logic [CntW-1:0] tmr_load_val, tmr_limit;

  // Host only wins if the previous grant went to the scan, so neither side can starve.
  assign host_win = (state_q == ARB) && hreq && !last_host_q;
  assign arb_chnl = host_win ? hchnl : SLOT_CHNL[slot_q];
  assign tmo_fire = (state_q == WAIT) && !cnv_cmplt && tmr_expired;

  // Reloading with 1 after a store/timeout makes strt_cnv land GAP_CYCLES+1 clks later.
  assign tmr_load     = (state_q == ARB) || (state_q == STORE) || tmo_fire;
  assign tmr_load_val = (state_q == ARB) ? '0 : CntW'(1);
  assign tmr_en       = (state_q == GAP) || (state_q == WAIT);
  assign tmr_limit    = (state_q == GAP) ? GapLim : WaitLim;

  sched_timer #(
    .WIDTH(CntW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .limit    (tmr_limit),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    last_host_d  = last_host_q;
    owner_host_d = owner_host_q;
    chnnl_d      = chnnl_q;
    gain_d       = gain_q;
    gain_vld_d   = gain_vld_q;
    scan_err_d   = scan_err_q;
    hres_d       = hres_q;
    hvld_d       = 1'b0;
    herr_d       = 1'b0;
    strt_cnv     = 1'b0;
    hgnt         = 1'b0;

    unique case (state_q)
      GAP: begin
        if (tmr_expired) state_d = ARB;
      end
      ARB: begin
        strt_cnv     = 1'b1;
        hgnt         = host_win;
        chnnl_d      = arb_chnl;
        owner_host_d = host_win;
        last_host_d  = host_win;
        state_d      = WAIT;
      end
      WAIT: begin
        // Completion takes precedence over a coincident timeout.
        if (cnv_cmplt) begin
          state_d = STORE;
          if (owner_host_q) begin
            hres_d = res;
            hvld_d = 1'b1;
          end else begin
            gain_d[slot_q]     = res;
            gain_vld_d[slot_q] = 1'b1;
            slot_d             = next_slot(slot_q);
          end
        end else if (tmr_expired) begin
          state_d = GAP;
          if (owner_host_q) begin
            hvld_d = 1'b1;
            herr_d = 1'b1;
          end else begin
            scan_err_d = 1'b1;
            slot_d     = next_slot(slot_q);
          end
        end
      end
      STORE: begin
        state_d = GAP;
      end
      default: begin
        state_d = GAP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= GAP;
      slot_q       <= '0;
      last_host_q  <= 1'b0;
      owner_host_q <= 1'b0;
      chnnl_q      <= '0;
      gain_q       <= '{default: '0};
      gain_vld_q   <= '0;
      scan_err_q   <= 1'b0;
      hres_q       <= '0;
      hvld_q       <= 1'b0;
      herr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      last_host_q  <= last_host_d;
      owner_host_q <= owner_host_d;
      chnnl_q      <= chnnl_d;
      gain_q       <= gain_d;
      gain_vld_q   <= gain_vld_d;
      scan_err_q   <= scan_err_d;
      hres_q       <= hres_d;
      hvld_q       <= hvld_d;
      herr_q       <= herr_d;
    end
  end

  assign chnnl    = (state_q == ARB) ? arb_chnl : chnnl_q;
  assign hres     = hres_q;
  assign hvld     = hvld_q;
  assign herr     = herr_q;
  assign gain_vld = gain_vld_q;
  assign scan_err = scan_err_q;

  assign LP_gain = gain_q[SLOT_LP];
  assign B1_gain = gain_q[SLOT_B1];
  assign B2_gain = gain_q[SLOT_B2];
  assign B3_gain = gain_q[SLOT_B3];
  assign HP_gain = gain_q[SLOT_HP];
  assign VOLUME  = gain_q[SLOT_VOL];

endmodule

// File: tb/tb_pot_scan_sched.sv
// Bench for pot_scan_sched with a behavioural A2D that answers 12'h100*chnl + 12'h0AB.
module tb_pot_scan_sched;

  localparam int unsigned G = 16;
  localparam int unsigned T = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        hreq;
  logic [2:0]  hchnl;
  logic        hgnt;
  logic [11:0] hres;
  logic        hvld;
  logic        herr;
  logic [11:0] LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME;
  logic [5:0]  gain_vld;
  logic        scan_err;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int exp_slot = 0;

  logic [2:0] exp_map [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  logic [3:0]  sb_q [$];   // {hgnt, chnnl} expected at each strt_cnv
  logic [12:0] hq [$];     // {herr, hres} expected at each hvld
  logic [12:0] got_h [$];  // {herr, hres} observed at each hvld

  always #5 clk = ~clk;

  pot_scan_sched #(
    .GAP_CYCLES(G),
    .TIMEOUT   (T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .hreq      (hreq),
    .hchnl     (hchnl),
    .hgnt      (hgnt),
    .hres      (hres),
    .hvld      (hvld),
    .herr      (herr),
    .LP_gain   (LP_gain),
    .B1_gain   (B1_gain),
    .B2_gain   (B2_gain),
    .B3_gain   (B3_gain),
    .HP_gain   (HP_gain),
    .VOLUME    (VOLUME),
    .gain_vld  (gain_vld),
    .scan_err  (scan_err)
  );

  // A2D model: answers 4 clks after strt_cnv unless its channel is gagged.
  logic        m_cmplt, m_busy, spur;
  logic [2:0]  m_ch;
  logic [11:0] m_res;
  int          m_cnt;
  int          gag_ch = -1;

  assign cnv_cmplt = m_cmplt | spur;
  assign res       = m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_cmplt <= 1'b0; m_cnt <= 0; m_ch <= 3'd0; m_res <= 12'h000;
    end else begin
      m_cmplt <= 1'b0;
      if (strt_cnv) begin
        m_busy <= 1'b1; m_cnt <= 3; m_ch <= chnnl;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          if (int'(m_ch) != gag_ch) begin
            m_cmplt <= 1'b1;
            m_res   <= 12'h100 * m_ch + 12'h0AB;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  function automatic logic [11:0] exp_res(input logic [2:0] ch);
    return 12'h100 * ch + 12'h0AB;
  endfunction

  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (hvld) got_h.push_back({herr, hres});
  endtask

  task automatic wait_strt(output logic [2:0] ch, output logic gnt, output int at);
    ch = 3'd0; gnt = 1'b0; at = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (strt_cnv) begin
        ch = chnnl; gnt = hgnt; at = ncyc;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL strt_cnv_wait: no strt_cnv within 3000 clks");
  endtask

  task automatic test_reset();
    logic [2:0] ch; logic gnt; int at, t0;
    rst = 1'b0; hreq = 1'b0; hchnl = 3'd0; spur = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({strt_cnv, hgnt, hvld, herr, scan_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000", {strt_cnv, hgnt, hvld, herr, scan_err});
    end
    checks++;
    if ({chnnl, hres, gain_vld} !== 21'h0) begin
      failures++;
      $display("FAIL reset_chnl_hres_vld: got %h want 0", {chnnl, hres, gain_vld});
    end
    checks++;
    if ({LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME} !== 72'h0) begin
      failures++;
      $display("FAIL reset_gains: got %h want 0",
               {LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME});
    end
    rst = 1'b0;
    t0 = ncyc;
    wait_strt(ch, gnt, at);
    checks++;
    if (at - t0 != G + 1) begin
      failures++;
      $display("FAIL reset_first_strt_latency: got %0d want %0d", at - t0, G + 1);
    end
    checks++;
    if (ch !== 3'd1) begin
      failures++;
      $display("FAIL reset_first_chnl: got %0d want 1", ch);
    end
    exp_slot = 1;
  endtask

  task automatic test_scan_pass();
    logic [2:0] ch; logic gnt; int at, t_s;
    logic [3:0] e;
    for (int s = 1; s < 6; s++) sb_q.push_back({1'b0, exp_map[s]});
    for (int k = 0; k < 5; k++) begin
      wait_strt(ch, gnt, at);
      e = sb_q.pop_front();
      checks++;
      if ({gnt, ch} !== e) begin
        failures++;
        $display("FAIL scan_seq[%0d]: got gnt=%b ch=%0d want gnt=%b ch=%0d",
                 k, gnt, ch, e[3], e[2:0]);
      end
    end
    exp_slot = 0;
    t_s = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (gain_vld == 6'h3F) begin
        t_s = ncyc;
        break;
      end
    end
    checks++;
    if (gain_vld !== 6'h3F) begin
      failures++;
      $display("FAIL scan_gain_vld: got %h want 3f", gain_vld);
    end
    checks++;
    if ({LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME} !==
        {12'h1AB, 12'h0AB, 12'h4AB, 12'h2AB, 12'h3AB, 12'h7AB}) begin
      failures++;
      $display("FAIL scan_gains: got %h want 1ab0ab4ab2ab3ab7ab",
               {LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME});
    end
    wait_strt(ch, gnt, at);
    checks++;
    if (at - t_s != G + 1) begin
      failures++;
      $display("FAIL store_to_strt_latency: got %0d want %0d", at - t_s, G + 1);
    end
    checks++;
    if (ch !== exp_map[exp_slot]) begin
      failures++;
      $display("FAIL scan_wrap_chnl: got %0d want %0d", ch, exp_map[exp_slot]);
    end
    exp_slot = 1;
  endtask

  task automatic test_host();
    logic [2:0] ch; logic gnt; int at;
    logic [12:0] e;
    tick();
    checks++;
    if (hgnt !== 1'b0) begin
      failures++;
      $display("FAIL host_no_grant_in_wait: got %b want 0", hgnt);
    end
    hreq = 1'b1; hchnl = 3'd5;
    hq.push_back({1'b0, exp_res(3'd5)});
    got_h.delete();
    wait_strt(ch, gnt, at);
    checks++;
    if ({gnt, ch} !== {1'b1, 3'd5}) begin
      failures++;
      $display("FAIL host_grant: got gnt=%b ch=%0d want gnt=1 ch=5", gnt, ch);
    end
    tick();
    hreq = 1'b0;
    wait_strt(ch, gnt, at);
    checks++;
    if ({gnt, ch} !== {1'b0, exp_map[exp_slot]}) begin
      failures++;
      $display("FAIL host_then_scan: got gnt=%b ch=%0d want gnt=0 ch=%0d",
               gnt, ch, exp_map[exp_slot]);
    end
    exp_slot = 2;
    checks++;
    if (got_h.size() != 1) begin
      failures++;
      $display("FAIL host_hvld_pulses: got %0d want 1", got_h.size());
    end else begin
      e = hq.pop_front();
      checks++;
      if (got_h[0] !== e) begin
        failures++;
        $display("FAIL host_hres: got %h want %h", got_h[0], e);
      end
    end
    hq.delete();
  endtask

  task automatic test_alternate();
    logic [2:0] ch; logic gnt; int at;
    logic [3:0] e;
    tick();
    hreq = 1'b1; hchnl = 3'd6;
    got_h.delete();
    for (int k = 0; k < 6; k++) begin
      sb_q.push_back({1'b1, 3'd6});
      sb_q.push_back({1'b0, exp_map[(exp_slot + k) % 6]});
      hq.push_back({1'b0, exp_res(3'd6)});
    end
    for (int k = 0; k < 12; k++) begin
      wait_strt(ch, gnt, at);
      e = sb_q.pop_front();
      checks++;
      if ({gnt, ch} !== e) begin
        failures++;
        $display("FAIL alt_seq[%0d]: got gnt=%b ch=%0d want gnt=%b ch=%0d",
                 k, gnt, ch, e[3], e[2:0]);
      end
    end
    tick();
    hreq = 1'b0;
    checks++;
    if (got_h.size() != 6) begin
      failures++;
      $display("FAIL alt_host_results: got %0d want 6", got_h.size());
    end
    while (got_h.size() > 0 && hq.size() > 0) begin
      logic [12:0] g, w;
      g = got_h.pop_front();
      w = hq.pop_front();
      checks++;
      if (g !== w) begin
        failures++;
        $display("FAIL alt_hres: got %h want %h", g, w);
      end
    end
    hq.delete();
  endtask

  task automatic test_timeout();
    logic [2:0] ch; logic gnt; int at, t_a, t_h;
    gag_ch = 4;
    wait_strt(ch, gnt, at);
    t_a = at;
    checks++;
    if ({gnt, ch} !== {1'b0, 3'd4}) begin
      failures++;
      $display("FAIL tmo_slot2_chnl: got gnt=%b ch=%0d want gnt=0 ch=4", gnt, ch);
    end
    repeat (T) tick();
    checks++;
    if (scan_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_scan_err_early: got %b want 0", scan_err);
    end
    tick();
    checks++;
    if (scan_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_scan_err: got %b want 1", scan_err);
    end
    checks++;
    if ({B2_gain, gain_vld} !== {12'h4AB, 6'h3F}) begin
      failures++;
      $display("FAIL tmo_b2_kept: got %h want 4ab3f", {B2_gain, gain_vld});
    end
    wait_strt(ch, gnt, at);
    checks++;
    if ({ch, at - t_a} !== {3'd2, 32'(T + G + 1)}) begin
      failures++;
      $display("FAIL tmo_next_slot: got ch=%0d dt=%0d want ch=2 dt=%0d", ch, at - t_a, T + G + 1);
    end
    tick();
    hreq = 1'b1; hchnl = 3'd4;
    got_h.delete();
    hq.push_back({1'b1, 12'h6AB});
    wait_strt(ch, gnt, at);
    t_h = at;
    checks++;
    if ({gnt, ch} !== {1'b1, 3'd4}) begin
      failures++;
      $display("FAIL tmo_host_grant: got gnt=%b ch=%0d want gnt=1 ch=4", gnt, ch);
    end
    tick();
    hreq = 1'b0;
    wait_strt(ch, gnt, at);
    checks++;
    if ({gnt, ch, at - t_h} !== {1'b0, 3'd3, 32'(T + G + 1)}) begin
      failures++;
      $display("FAIL tmo_after_host: got gnt=%b ch=%0d dt=%0d want gnt=0 ch=3 dt=%0d",
               gnt, ch, at - t_h, T + G + 1);
    end
    checks++;
    if (got_h.size() != 1 || got_h[0] !== hq[0]) begin
      failures++;
      $display("FAIL tmo_host_herr: got n=%0d v=%h want n=1 v=%h",
               got_h.size(), (got_h.size() > 0) ? got_h[0] : 13'h0, hq[0]);
    end
    hq.delete();
    checks++;
    if (scan_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_scan_err_sticky: got %b want 1", scan_err);
    end
    gag_ch = -1;
    exp_slot = 5;
  endtask

  task automatic test_rst_mid();
    logic [2:0] ch; logic gnt; int at, t0;
    tick();
    tick();
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if ({strt_cnv, chnnl, hres, gain_vld, scan_err, hvld, herr, hgnt} !== 26'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {strt_cnv, chnnl, hres, gain_vld, scan_err, hvld, herr, hgnt});
    end
    checks++;
    if ({LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME} !== 72'h0) begin
      failures++;
      $display("FAIL rst_mid_gains: got %h want 0",
               {LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME});
    end
    rst = 1'b0;
    t0 = ncyc;
    wait_strt(ch, gnt, at);
    checks++;
    if ({ch, at - t0} !== {3'd1, 32'(G + 1)}) begin
      failures++;
      $display("FAIL rst_mid_restart: got ch=%0d dt=%0d want ch=1 dt=%0d", ch, at - t0, G + 1);
    end
    exp_slot = 1;
  endtask

  task automatic test_spurious();
    logic [2:0] ch; logic gnt; int at, t_s;
    t_s = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (gain_vld == 6'h01) begin
        t_s = ncyc;
        break;
      end
    end
    repeat (5) tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    checks++;
    if ({gain_vld, LP_gain, B1_gain} !== {6'h01, 12'h1AB, 12'h000}) begin
      failures++;
      $display("FAIL spur_regs: got %h want 011ab000", {gain_vld, LP_gain, B1_gain});
    end
    wait_strt(ch, gnt, at);
    checks++;
    if ({ch, at - t_s} !== {exp_map[exp_slot], 32'(G + 1)}) begin
      failures++;
      $display("FAIL spur_timing: got ch=%0d dt=%0d want ch=%0d dt=%0d",
               ch, at - t_s, exp_map[exp_slot], G + 1);
    end
  endtask

  initial begin
    test_reset();
    test_scan_pass();
    test_host();
    test_alternate();
    test_timeout();
    test_rst_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
